spu_shift_rotate_pipe: RTL and testbench

SPU_SHIFT_ROTATE_PIPE -- requirements
Module: spu_shift_rotate_pipe

---
 rtl/spu_pkg.sv | 39 +++
 rtl/spu_lane_shifter.sv | 41 ++++
 rtl/spu_shift_rotate_pipe.sv | 130 +++++++++++++
 tb/tb_spu_shift_rotate_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared definitions for the SPU shift/rotate pipeline: opcodes, quadword
// type, stage records and lane-shifter control enums.
package spu_pkg;

    localparam logic [10:0] OP_SHLH = 11'b00001011111;
    localparam logic [10:0] OP_SHL  = 11'b00001011011;
    localparam logic [10:0] OP_ROTH = 11'b00001011100;
    localparam logic [10:0] OP_ROT  = 11'b00001011000;

    typedef logic [127:0] quad_t;

    // Issue-stage record: the raw instruction as accepted.
    typedef struct packed {
        logic        valid;
        logic [10:0] opcode;
        quad_t       ra;
        quad_t       rb;
        logic [6:0]  rt_addr;
    } stage_rec_t;

    // Result-stage record carried from stage 2 to writeback.
    typedef struct packed {
        logic       valid;
        quad_t      rt;
        logic [6:0] addr;
        logic       illegal;
    } wb_rec_t;

    typedef enum logic {
        SH_SHIFT  = 1'b0,
        SH_ROTATE = 1'b1
    } shift_mode_e;

    typedef enum logic {
        LANE_WORD = 1'b0,
        LANE_HALF = 1'b1
    } lane_size_e;

endpackage

// File: rtl/spu_lane_shifter.sv
// One halfword or word lane of the SPU shifter: left shift with zero fill
// (count at or beyond lane width gives zero) or left rotate.
// Rotate support is present only when SPU_ROTATE_EN is defined.
module spu_lane_shifter
    import spu_pkg::*;
#(
    parameter lane_size_e SIZE = LANE_WORD,
    localparam int unsigned W  = (SIZE == LANE_HALF) ? 16 : 32,
    localparam int unsigned CW = (SIZE == LANE_HALF) ? 5 : 6
) (
    input  logic [W-1:0]  i_operand,
    input  logic [CW-1:0] i_count,
    input  shift_mode_e   i_mode,
    output logic [W-1:0]  o_result
);

`ifdef SPU_ROTATE_EN
    logic [CW-1:0] w_rsh;

    // Rotate is the OR of a left shift and the complementary right shift;
    // a zero rotate count gives a right shift by W, which is zero.
    always_comb begin
        w_rsh = CW'(W) - {1'b0, i_count[CW-2:0]};
        if (i_mode == SH_ROTATE)
            o_result = (i_operand << i_count[CW-2:0]) | (i_operand >> w_rsh);
        else if (i_count[CW-1])
            o_result = '0;
        else
            o_result = i_operand << i_count[CW-2:0];
    end
`else
    // Shift only; the MSB of the count marks an out-of-range shift.
    always_comb begin
        if (i_mode == SH_ROTATE || i_count[CW-1])
            o_result = '0;
        else
            o_result = i_operand << i_count[CW-2:0];
    end
`endif

endmodule

// File: rtl/spu_shift_rotate_pipe.sv
// SPU RR-form shift/rotate pipeline (shlh, shl, roth, rot) with LATENCY
// issue-to-result cycles (legal 2..6), stall hold and flush kill.
// Define SPU_ROTATE_EN to enable roth/rot; otherwise they report illegal.
module spu_shift_rotate_pipe
    import spu_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic [10:0]  opcode,
    input  logic [127:0] register_RA,
    input  logic [127:0] register_RB,
    input  logic [6:0]   rt_addr,
    input  logic         stall,
    input  logic         flush,
    output logic         wb_valid,
    output logic [127:0] register_RT,
    output logic [6:0]   wb_addr,
    output logic         wb_illegal,
    output logic         busy
);

    stage_rec_t  r_s1;
    wb_rec_t     r_st [2:LATENCY];

    quad_t       w_half_q;
    quad_t       w_word_q;
    quad_t       w_result;
    logic        w_illegal;
    shift_mode_e w_half_mode;
    shift_mode_e w_word_mode;
    logic        w_unused_rb;

    // Only the count fields of RB feed the lanes.
    assign w_unused_rb = ^r_s1.rb;

    for (genvar g = 0; g < 8; g++) begin : g_half
        spu_lane_shifter #(.SIZE(LANE_HALF)) u_lane (
            .i_operand (r_s1.ra[16*g +: 16]),
            .i_count   (r_s1.rb[16*g +: 5]),
            .i_mode    (w_half_mode),
            .o_result  (w_half_q[16*g +: 16])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_word
        spu_lane_shifter #(.SIZE(LANE_WORD)) u_lane (
            .i_operand (r_s1.ra[32*g +: 32]),
            .i_count   (r_s1.rb[32*g +: 6]),
            .i_mode    (w_word_mode),
            .o_result  (w_word_q[32*g +: 32])
        );
    end

    // Decode the stage-1 opcode into lane modes and pick the result.
    always_comb begin
        w_half_mode = SH_SHIFT;
        w_word_mode = SH_SHIFT;
        w_result    = '0;
        w_illegal   = 1'b0;
        case (r_s1.opcode)
            OP_SHLH: w_result = w_half_q;
            OP_SHL:  w_result = w_word_q;
`ifdef SPU_ROTATE_EN
            OP_ROTH: begin
                w_half_mode = SH_ROTATE;
                w_result    = w_half_q;
            end
            OP_ROT: begin
                w_word_mode = SH_ROTATE;
                w_result    = w_word_q;
            end
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // Pipeline advance: flush kills valids, stall holds, data moves only
    // with a valid so the writeback stage keeps its last result when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            for (int unsigned k = 2; k <= LATENCY; k++)
                r_st[k] <= '0;
        end else if (flush) begin
            r_s1.valid <= 1'b0;
            for (int unsigned k = 2; k <= LATENCY; k++)
                r_st[k].valid <= 1'b0;
        end else if (!stall) begin
            r_s1.valid <= issue_valid;
            if (issue_valid) begin
                r_s1.opcode  <= opcode;
                r_s1.ra      <= register_RA;
                r_s1.rb      <= register_RB;
                r_s1.rt_addr <= rt_addr;
            end
            r_st[2].valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_st[2].rt      <= w_result;
                r_st[2].addr    <= r_s1.rt_addr;
                r_st[2].illegal <= w_illegal;
            end
            for (int unsigned k = 3; k <= LATENCY; k++) begin
                r_st[k].valid <= r_st[k-1].valid;
                if (r_st[k-1].valid) begin
                    r_st[k].rt      <= r_st[k-1].rt;
                    r_st[k].addr    <= r_st[k-1].addr;
                    r_st[k].illegal <= r_st[k-1].illegal;
                end
            end
        end
    end

    // Any valid stage, including writeback, marks the unit busy.
    always_comb begin
        busy = r_s1.valid;
        for (int unsigned k = 2; k <= LATENCY; k++)
            busy = busy | r_st[k].valid;
    end

    assign issue_ready = !stall && !flush;
    assign wb_valid    = r_st[LATENCY].valid;
    assign register_RT = r_st[LATENCY].rt;
    assign wb_addr     = r_st[LATENCY].addr;
    assign wb_illegal  = r_st[LATENCY].illegal;

endmodule

// File: tb/tb_spu_shift_rotate_pipe.sv
// Scoreboard bench for spu_shift_rotate_pipe: directed cases plus random
// traffic with stalls and flushes, checked against a bit-level model.
module tb_spu_shift_rotate_pipe;
    import spu_pkg::*;

    localparam int unsigned LAT = 4;

    logic         clk, reset, issue_valid, issue_ready, stall, flush;
    logic [10:0]  opcode;
    logic [127:0] register_RA, register_RB, register_RT;
    logic [6:0]   rt_addr, wb_addr;
    logic         wb_valid, wb_illegal, busy;

    spu_shift_rotate_pipe #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .register_RA(register_RA), .register_RB(register_RB),
        .rt_addr(rt_addr), .stall(stall), .flush(flush), .wb_valid(wb_valid),
        .register_RT(register_RT), .wb_addr(wb_addr), .wb_illegal(wb_illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] rt;
        logic [6:0]   addr;
        logic         ill;
        int unsigned  edge_n;
        int unsigned  stalls_n;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned edge_cnt = 0;
    int unsigned stall_cnt = 0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (stall && !flush && !reset) stall_cnt <= stall_cnt + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: bit-by-bit placement of each lane from the rules.
    function automatic logic [128:0] ref_model(input logic [10:0] op, input logic [127:0] ra,
                                               input logic [127:0] rb);
        logic [127:0] rt;
        logic         ill;
        int unsigned  c;
        rt  = '0;
        ill = 1'b0;
        if (op == OP_SHLH) begin
            for (int i = 0; i < 8; i++) begin
                c = rb[16*i +: 5];
                for (int j = 0; j < 16; j++)
                    if (j + c < 16) rt[16*i + j + c] = ra[16*i + j];
            end
        end else if (op == OP_SHL) begin
            for (int i = 0; i < 4; i++) begin
                c = rb[32*i +: 6];
                for (int j = 0; j < 32; j++)
                    if (j + c < 32) rt[32*i + j + c] = ra[32*i + j];
            end
`ifdef SPU_ROTATE_EN
        end else if (op == OP_ROTH) begin
            for (int i = 0; i < 8; i++) begin
                c = rb[16*i +: 4];
                for (int j = 0; j < 16; j++) rt[16*i + (j + c) % 16] = ra[16*i + j];
            end
        end else if (op == OP_ROT) begin
            for (int i = 0; i < 4; i++) begin
                c = rb[32*i +: 5];
                for (int j = 0; j < 32; j++) rt[32*i + (j + c) % 32] = ra[32*i + j];
            end
`endif
        end else begin
            ill = 1'b1;
        end
        return {ill, rt};
    endfunction

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [10:0] op, input logic [127:0] ra,
                       input logic [127:0] rb, input logic [6:0] a, input logic st,
                       input logic fl, input logic use_lit, input logic [127:0] lit_rt,
                       input logic lit_ill);
        logic [128:0] m;
        exp_t e;
        issue_valid = v; opcode = op; register_RA = ra; register_RB = rb;
        rt_addr = a; stall = st; flush = fl;
        #1;
        chk("issue_ready", {127'b0, issue_ready}, {127'b0, !st && !fl});
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (v && !st) begin
            m = ref_model(op, ra, rb);
            e.rt       = use_lit ? lit_rt : m[127:0];
            e.ill      = use_lit ? lit_ill : m[128];
            e.addr     = a;
            e.edge_n   = edge_cnt;
            e.stalls_n = stall_cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc_m(input logic v, input logic [10:0] op, input logic [127:0] ra,
                         input logic [127:0] rb, input logic [6:0] a, input logic st,
                         input logic fl);
        cyc(v, op, ra, rb, a, st, fl, 1'b0, '0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_m(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            idle(1);
            n++;
        end
        chk("drain_timeout", 128'(exp_q.size()), '0);
        idle(1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [10:0] rnd_op();
        case ($urandom_range(0, 4))
            0: return OP_SHLH;
            1: return OP_SHL;
            2: return OP_ROTH;
            3: return OP_ROT;
            default: return 11'($urandom);
        endcase
    endfunction

    // Monitor: pops on each newly presented result, checks holds otherwise.
    initial begin
        logic s, f, mv;
        exp_t last, e;
        int unsigned lat;
        mv = 1'b0;
        last = '{default: '0};
        forever begin
            @(posedge clk);
            s = stall; f = flush;
            @(negedge clk);
            if (reset) begin
                mv = 1'b0;
                last = '{default: '0};
                continue;
            end
            chk("busy", {127'b0, busy}, {127'b0, (exp_q.size() != 0) || wb_valid});
            if (f) begin
                chk("flush_wb_valid", {127'b0, wb_valid}, '0);
                mv = 1'b0;
            end else if (s) begin
                chk("stall_wb_valid", {127'b0, wb_valid}, {127'b0, mv});
                chk("stall_rt", register_RT, last.rt);
                chk("stall_addr", {121'b0, wb_addr}, {121'b0, last.addr});
                chk("stall_ill", {127'b0, wb_illegal}, {127'b0, last.ill});
            end else if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", {127'b0, wb_valid}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rt", register_RT, e.rt);
                    chk("wb_addr", {121'b0, wb_addr}, {121'b0, e.addr});
                    chk("wb_illegal", {127'b0, wb_illegal}, {127'b0, e.ill});
                    lat = (edge_cnt - e.edge_n) - (stall_cnt - e.stalls_n);
                    chk("latency", 128'(lat), 128'(LAT - 1));
                    last = e;
                end
                mv = 1'b1;
            end else begin
                mv = 1'b0;
                chk("idle_rt", register_RT, last.rt);
                chk("idle_addr", {121'b0, wb_addr}, {121'b0, last.addr});
                chk("idle_ill", {127'b0, wb_illegal}, {127'b0, last.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ra, rb, ex;
        reset = 1'b1; issue_valid = 1'b0; opcode = '0; register_RA = '0;
        register_RB = '0; rt_addr = '0; stall = 1'b0; flush = 1'b0;
        #2;
        chk("rst_wb_valid", {127'b0, wb_valid}, '0);
        chk("rst_rt", register_RT, '0);
        chk("rst_addr", {121'b0, wb_addr}, '0);
        chk("rst_ill", {127'b0, wb_illegal}, '0);
        chk("rst_busy", {127'b0, busy}, '0);
        chk("rst_ready", {127'b0, issue_ready}, 128'd1);
        stall = 1'b1; #1;
        chk("rst_ready_stall", {127'b0, issue_ready}, '0);
        stall = 1'b0;
        @(posedge clk); @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;

        // shlh by 3 on 0x0001 halfwords
        cyc(1'b1, OP_SHLH, {8{16'h0001}}, {8{16'h0003}}, 7'd1, 1'b0, 1'b0,
            1'b1, {8{16'h0008}}, 1'b0);
        drain();

        // shlh count boundaries 16 and 15
        cyc(1'b1, OP_SHLH, '1, {96'h0, 16'h000F, 16'h0010}, 7'd2, 1'b0, 1'b0,
            1'b1, {{6{16'hFFFF}}, 16'h8000, 16'h0000}, 1'b0);
        drain();

        // shl and rot by 1 on 0x80000001 words
        cyc(1'b1, OP_SHL, {4{32'h8000_0001}}, {4{32'h1}}, 7'd3, 1'b0, 1'b0,
            1'b1, {4{32'h0000_0002}}, 1'b0);
`ifdef SPU_ROTATE_EN
        ex = {4{32'h0000_0003}};
        cyc(1'b1, OP_ROT, {4{32'h8000_0001}}, {4{32'h1}}, 7'd4, 1'b0, 1'b0, 1'b1, ex, 1'b0);
`else
        cyc(1'b1, OP_ROT, {4{32'h8000_0001}}, {4{32'h1}}, 7'd4, 1'b0, 1'b0, 1'b1, '0, 1'b1);
`endif
        drain();

        // Five back-to-back with a two-cycle stall after the second issue
        for (int i = 0; i < 7; i++) begin
            ra = rnd128(); rb = rnd128();
            cyc_m(1'b1, (i % 2 == 0) ? OP_SHL : OP_SHLH, ra, rb, 7'(10 + i),
                  (i == 2 || i == 3), 1'b0);
        end
        drain();

        // Three issues then flush together with a fourth
        for (int i = 0; i < 3; i++) cyc_m(1'b1, OP_SHL, rnd128(), rnd128(), 7'(20 + i), 1'b0, 1'b0);
        cyc_m(1'b1, OP_SHLH, rnd128(), rnd128(), 7'd23, 1'b0, 1'b1);
        idle(8);

        // Illegal opcode to register 42
        cyc(1'b1, 11'h7FF, rnd128(), rnd128(), 7'd42, 1'b0, 1'b0, 1'b1, '0, 1'b1);
        drain();

        // Reset in mid-flight
        cyc_m(1'b1, OP_SHL, rnd128(), rnd128(), 7'd50, 1'b0, 1'b0);
        cyc_m(1'b1, OP_SHLH, rnd128(), rnd128(), 7'd51, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_wb_valid", {127'b0, wb_valid}, '0);
        chk("midrst_rt", register_RT, '0);
        chk("midrst_addr", {121'b0, wb_addr}, '0);
        chk("midrst_busy", {127'b0, busy}, '0);
        @(posedge clk); #1 reset = 1'b0;
        idle(10);

        // Random traffic with occasional stall and flush
        for (int i = 0; i < 400; i++) begin
            cyc_m($urandom_range(0, 3) != 0, rnd_op(), rnd128(), rnd128(), 7'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
